intc_rr_arbiter: RTL and testbench
==================================

INTC_RR_ARBITER -- requirements
Module: intc_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter N_SRC, default 4, SHALL set the number of interrupt sources; only 4 is supported.
REQ-003 Parameter ADDR_W, default 32, SHALL set the width of ISR addresses.
REQ-004 clk  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous reset, active low.
REQ-006 done  input  4  SHALL carry the per-source interrupt request levels from the accelerators.
REQ-007 IACK  input  1  SHALL be the CPU interrupt acknowledge, a 1-cycle pulse.
REQ-008 eoi  input  1  SHALL be the CPU end-of-interrupt, a 1-cycle pulse.
REQ-009 mask_we  input  1  SHALL be the mask register write enable.
REQ-010 mask_wdata  input  4  SHALL be the mask write data; bit i=1 masks source i.
REQ-011 isr_addr0..isr_addr3  input  ADDR_W each  SHALL be the ISR address table entries.
REQ-012 IRQ  output  1  SHALL be the interrupt request to the CPU.
REQ-013 isr_addr  output  ADDR_W  SHALL be the ISR address of the granted source.
REQ-014 active_id  output  2  SHALL be the index of the granted source.
REQ-015 pending  output  4  SHALL be the pending-request register.
REQ-016 mask  output  4  SHALL be the current mask register.
REQ-017 busy  output  1  SHALL be high in states REQ and SERVICE.
REQ-018 error  output  1  SHALL be a 1-cycle pulse on a protocol violation.

Function
REQ-019 The block SHALL register done into done_prev each cycle, and SHALL set pending[i] on each cycle where done[i] & ~done_prev[i].
REQ-020 A pending bit SHALL be set regardless of mask; a masked source SHALL stay pending but SHALL be ineligible for grant.
REQ-021 A mask_we pulse SHALL load mask from mask_wdata at the next edge.
REQ-022 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-023 In IDLE, when eligible = pending & ~mask is non-zero, the block SHALL select a source round-robin starting at ptr and searching upward mod 4.
REQ-024 On that selection in IDLE, the block SHALL latch active_id, latch isr_addr from the table entry for that source, and enter REQ.
REQ-025 IRQ SHALL equal (state==REQ) and SHALL be registered, so it is high from the cycle after selection.
REQ-026 In REQ on IACK, the block SHALL clear pending[active_id], set ptr=active_id+1 (mod 4), and enter SERVICE; IRQ SHALL go low on the next cycle.
REQ-027 A grant SHALL be non-preemptive: a mask change, or a new request, during REQ or SERVICE SHALL NOT change active_id or isr_addr.
REQ-028 In SERVICE on eoi, the block SHALL return to IDLE, and arbitration SHALL restart in the following cycle.
REQ-029 isr_addr and active_id SHALL hold their value until the next grant.
REQ-030 Latency: with done[i] rising sampled at edge t, pending SHALL be visible after t, REQ entered at t+1, and IRQ high after t+1.
REQ-031 If a new rising edge on done[i] coincides with the IACK clearing pending[i], set SHALL win and the bit SHALL remain pending.
REQ-032 If IACK and eoi are both high in REQ, the block SHALL honour IACK only and SHALL pulse error.
REQ-033 IACK outside REQ, or eoi outside SERVICE, SHALL be ignored with no state change and SHALL pulse error for 1 cycle.
REQ-034 A level held high on done SHALL produce only one pending event.

Reset
REQ-035 While rst=0, the block SHALL asynchronously force: state=IDLE, IRQ=0, busy=0, error=0, isr_addr=0, active_id=0, pending=0, mask=0, ptr=0, done_prev=0.
REQ-036 If done[i] is high at reset release, it SHALL register as a rising edge at the first clock edge.
REQ-037 Reset asserted mid-service SHALL abandon the grant, and IRQ SHALL drop immediately.

Verification
REQ-038 Table={0x100,0x200,0x300,0x400}; pulse done[2] -> IRQ high 2 cycles later, isr_addr=0x300, active_id=2; IACK -> pending[2]=0, IRQ=0; eoi -> busy=0.
REQ-039 done=4'b1111 simultaneously after reset -> grants in order 0,1,2,3 across four IACK/eoi rounds; then done[0] and done[1] retriggered with ptr=0 -> grant 0 then 1.
REQ-040 mask=4'b0001, pulse done[0] -> pending[0]=1, IRQ stays 0; write mask=0 -> IRQ high 2 cycles later, isr_addr=0x100.
REQ-041 IACK while IDLE, and eoi while in REQ -> error pulses 1 cycle each, no state change; IACK and eoi together in REQ -> SERVICE entered, error pulses.
REQ-042 rst low during SERVICE with pending=4'b0110 -> all outputs 0 immediately; after release with done low, IRQ stays 0.
REQ-043 A new done[1] edge in the same cycle as the IACK for source 1 -> after IACK, pending[1]=1, and after eoi IRQ re-asserts for source 1.

Source files
------------

// File: rtl/intc_rr_arbiter.sv
// Round-robin interrupt controller for four accelerator sources: edge-detected
// pending bits, mask register, non-preemptive grant with IACK/EOI handshake.
module intc_rr_arbiter #(
  parameter int N_SRC  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  done,
  input  logic              IACK,
  input  logic              eoi,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic [ADDR_W-1:0] isr_addr0,
  input  logic [ADDR_W-1:0] isr_addr1,
  input  logic [ADDR_W-1:0] isr_addr2,
  input  logic [ADDR_W-1:0] isr_addr3,
  output logic              IRQ,
  output logic [ADDR_W-1:0] isr_addr,
  output logic [1:0]        active_id,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  mask,
  output logic              busy,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             state;
  logic [1:0]         ptr;
  logic [N_SRC-1:0]   done_prev;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   clr_vec;
  logic               found;
  logic [1:0]         sel_id;
  logic [1:0]         cand;
  logic [ADDR_W-1:0]  sel_addr;

  assign rise     = done & ~done_prev;
  assign eligible = pending & ~mask;

  // Search upward from ptr, wrapping mod 4; first eligible source wins.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = ptr + k[1:0];
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        sel_id = cand;
      end
    end
  end

  always_comb begin
    case (sel_id)
      2'd0:    sel_addr = isr_addr0;
      2'd1:    sel_addr = isr_addr1;
      2'd2:    sel_addr = isr_addr2;
      default: sel_addr = isr_addr3;
    endcase
  end

  always_comb begin
    clr_vec = '0;
    if (state == S_REQ && IACK) clr_vec[active_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      IRQ       <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      isr_addr  <= '0;
      active_id <= '0;
      pending   <= '0;
      mask      <= '0;
      ptr       <= '0;
      done_prev <= '0;
    end else begin
      done_prev <= done;
      if (mask_we) mask <= mask_wdata;
      // A new edge ORed in after the clear lets set win over IACK's clear.
      pending   <= (pending & ~clr_vec) | rise;
      error     <= (IACK && state != S_REQ) || (eoi && state != S_SERVICE);
      case (state)
        S_IDLE: begin
          if (found) begin
            state     <= S_REQ;
            active_id <= sel_id;
            isr_addr  <= sel_addr;
            IRQ       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_REQ: begin
          if (IACK) begin
            state <= S_SERVICE;
            ptr   <= active_id + 2'd1;
            IRQ   <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          IRQ   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intc_rr_arbiter.sv
// Directed bench for intc_rr_arbiter: vector table for the main handshake
// sequence plus hand-written reset and round-robin sequences.
module tb_intc_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  done;
  logic        IACK, eoi, mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] isr_addr0, isr_addr1, isr_addr2, isr_addr3;
  logic        IRQ;
  logic [31:0] isr_addr;
  logic [1:0]  active_id;
  logic [3:0]  pending, mask;
  logic        busy, error;

  int checks = 0;
  int errors = 0;

  intc_rr_arbiter #(.N_SRC(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .done(done), .IACK(IACK), .eoi(eoi),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .isr_addr0(isr_addr0), .isr_addr1(isr_addr1),
    .isr_addr2(isr_addr2), .isr_addr3(isr_addr3),
    .IRQ(IRQ), .isr_addr(isr_addr), .active_id(active_id),
    .pending(pending), .mask(mask), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  done;
    logic        iack, eoi, mwe;
    logic [3:0]  mwd;
    logic        irq, busy, err;
    logic [1:0]  id;
    logic [31:0] addr;
    logic [3:0]  pend, msk;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t mk(input logic [3:0] d, input logic ia, input logic eo,
                              input logic mw, input logic [3:0] md,
                              input logic irq, input logic bsy, input logic er,
                              input logic [1:0] id, input logic [31:0] ad,
                              input logic [3:0] pd, input logic [3:0] mk_);
    vec_t v;
    v.done = d; v.iack = ia; v.eoi = eo; v.mwe = mw; v.mwd = md;
    v.irq = irq; v.busy = bsy; v.err = er; v.id = id; v.addr = ad;
    v.pend = pd; v.msk = mk_;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic irq,
                         input logic bsy, input logic er, input logic [1:0] id,
                         input logic [31:0] ad, input logic [3:0] pd,
                         input logic [3:0] mk_);
    chk({nm, ".IRQ"}, idx, {31'd0, IRQ}, {31'd0, irq});
    chk({nm, ".busy"}, idx, {31'd0, busy}, {31'd0, bsy});
    chk({nm, ".error"}, idx, {31'd0, error}, {31'd0, er});
    chk({nm, ".active_id"}, idx, {30'd0, active_id}, {30'd0, id});
    chk({nm, ".isr_addr"}, idx, isr_addr, ad);
    chk({nm, ".pending"}, idx, {28'd0, pending}, {28'd0, pd});
    chk({nm, ".mask"}, idx, {28'd0, mask}, {28'd0, mk_});
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] d, input logic ia, input logic eo,
                      input logic mw, input logic [3:0] md);
    @(negedge clk);
    done = d; IACK = ia; eoi = eo; mask_we = mw; mask_wdata = md;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    done = '0; IACK = 0; eoi = 0; mask_we = 0; mask_wdata = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    done = '0; IACK = 0; eoi = 0; mask_we = 0; mask_wdata = '0;
    isr_addr0 = 32'h100; isr_addr1 = 32'h200;
    isr_addr2 = 32'h300; isr_addr3 = 32'h400;

    //            done  ia eo mw mwd    irq bsy err id addr    pend   msk
    tbl[0]  = mk(4'h4, 0, 0, 0, 4'h0,  0, 0, 0, 0, 32'h000, 4'h4, 4'h0);
    tbl[1]  = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 2, 32'h300, 4'h4, 4'h0);
    tbl[2]  = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 2, 32'h300, 4'h4, 4'h0);
    tbl[3]  = mk(4'h0, 1, 0, 0, 4'h0,  0, 1, 0, 2, 32'h300, 4'h0, 4'h0);
    tbl[4]  = mk(4'h0, 0, 0, 0, 4'h0,  0, 1, 0, 2, 32'h300, 4'h0, 4'h0);
    tbl[5]  = mk(4'h0, 0, 1, 0, 4'h0,  0, 0, 0, 2, 32'h300, 4'h0, 4'h0);
    tbl[6]  = mk(4'h0, 1, 0, 0, 4'h0,  0, 0, 1, 2, 32'h300, 4'h0, 4'h0);
    tbl[7]  = mk(4'h0, 0, 0, 0, 4'h0,  0, 0, 0, 2, 32'h300, 4'h0, 4'h0);
    tbl[8]  = mk(4'h2, 0, 0, 0, 4'h0,  0, 0, 0, 2, 32'h300, 4'h2, 4'h0);
    tbl[9]  = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[10] = mk(4'h0, 0, 1, 0, 4'h0,  1, 1, 1, 1, 32'h200, 4'h2, 4'h0);
    tbl[11] = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[12] = mk(4'h0, 1, 1, 0, 4'h0,  0, 1, 1, 1, 32'h200, 4'h0, 4'h0);
    tbl[13] = mk(4'h0, 0, 1, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h0, 4'h0);
    tbl[14] = mk(4'h0, 0, 0, 1, 4'h1,  0, 0, 0, 1, 32'h200, 4'h0, 4'h1);
    tbl[15] = mk(4'h1, 0, 0, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h1, 4'h1);
    tbl[16] = mk(4'h0, 0, 0, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h1, 4'h1);
    tbl[17] = mk(4'h0, 0, 0, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h1, 4'h1);
    tbl[18] = mk(4'h0, 0, 0, 1, 4'h0,  0, 0, 0, 1, 32'h200, 4'h1, 4'h0);
    tbl[19] = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 0, 32'h100, 4'h1, 4'h0);
    tbl[20] = mk(4'h0, 1, 0, 0, 4'h0,  0, 1, 0, 0, 32'h100, 4'h0, 4'h0);
    tbl[21] = mk(4'h0, 0, 1, 0, 4'h0,  0, 0, 0, 0, 32'h100, 4'h0, 4'h0);
    tbl[22] = mk(4'h2, 0, 0, 0, 4'h0,  0, 0, 0, 0, 32'h100, 4'h2, 4'h0);
    tbl[23] = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[24] = mk(4'h2, 1, 0, 0, 4'h0,  0, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[25] = mk(4'h0, 0, 0, 0, 4'h0,  0, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[26] = mk(4'h0, 0, 1, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[27] = mk(4'h0, 0, 0, 0, 4'h0,  1, 1, 0, 1, 32'h200, 4'h2, 4'h0);
    tbl[28] = mk(4'h0, 1, 0, 0, 4'h0,  0, 1, 0, 1, 32'h200, 4'h0, 4'h0);
    tbl[29] = mk(4'h0, 0, 1, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h0, 4'h0);
    tbl[30] = mk(4'h1, 0, 0, 0, 4'h0,  0, 0, 0, 1, 32'h200, 4'h1, 4'h0);
    tbl[31] = mk(4'h1, 0, 0, 0, 4'h0,  1, 1, 0, 0, 32'h100, 4'h1, 4'h0);
    tbl[32] = mk(4'h1, 1, 0, 0, 4'h0,  0, 1, 0, 0, 32'h100, 4'h0, 4'h0);
    tbl[33] = mk(4'h1, 0, 1, 0, 4'h0,  0, 0, 0, 0, 32'h100, 4'h0, 4'h0);
    tbl[34] = mk(4'h1, 0, 0, 0, 4'h0,  0, 0, 0, 0, 32'h100, 4'h0, 4'h0);
    tbl[35] = mk(4'h0, 0, 0, 0, 4'h0,  0, 0, 0, 0, 32'h100, 4'h0, 4'h0);

    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 36; i++) begin
      step(tbl[i].done, tbl[i].iack, tbl[i].eoi, tbl[i].mwe, tbl[i].mwd);
      chk_all("vec", i, tbl[i].irq, tbl[i].busy, tbl[i].err, tbl[i].id,
              tbl[i].addr, tbl[i].pend, tbl[i].msk);
    end

    // All four sources at once: grants must rotate 0,1,2,3.
    do_reset();
    step(4'hF, 0, 0, 0, 4'h0);
    chk("rr.pend_all", 0, {28'd0, pending}, 32'hF);
    step(4'h0, 0, 0, 0, 4'h0);
    for (int r = 0; r < 4; r++) begin
      chk("rr.irq", r, {31'd0, IRQ}, 32'd1);
      chk("rr.id", r, {30'd0, active_id}, r);
      chk("rr.addr", r, isr_addr, 32'h100 * (r + 1));
      step(4'h0, 1, 0, 0, 4'h0);
      chk("rr.pend", r, {28'd0, pending}, (32'hF << (r + 1)) & 32'hF);
      step(4'h0, 0, 1, 0, 4'h0);
      step(4'h0, 0, 0, 0, 4'h0);
    end
    chk("rr.idle_irq", 0, {31'd0, IRQ}, 32'd0);
    step(4'h3, 0, 0, 0, 4'h0);
    step(4'h0, 0, 0, 0, 4'h0);
    chk("rr.re_id0", 0, {30'd0, active_id}, 32'd0);
    chk("rr.re_irq0", 0, {31'd0, IRQ}, 32'd1);
    step(4'h0, 1, 0, 0, 4'h0);
    step(4'h0, 0, 1, 0, 4'h0);
    step(4'h0, 0, 0, 0, 4'h0);
    chk("rr.re_id1", 0, {30'd0, active_id}, 32'd1);
    chk("rr.re_addr1", 0, isr_addr, 32'h200);
    chk("rr.re_irq1", 0, {31'd0, IRQ}, 32'd1);

    // Asynchronous reset mid-service with two sources still pending.
    do_reset();
    step(4'h7, 0, 0, 0, 4'h0);
    step(4'h0, 0, 0, 0, 4'h0);
    step(4'h0, 1, 0, 0, 4'h0);
    chk("svc.pend", 0, {28'd0, pending}, 32'h6);
    chk("svc.busy", 0, {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    step(4'h0, 0, 0, 0, 4'h0);
    step(4'h0, 0, 0, 0, 4'h0);
    step(4'h0, 0, 0, 0, 4'h0);
    chk_all("post_rst", 0, 0, 0, 0, 0, 32'h0, 4'h0, 4'h0);

    // done already high across reset release counts as a rising edge.
    @(negedge clk);
    rst = 1'b0;
    done = 4'h8;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.pend", 0, {28'd0, pending}, 32'h8);
    step(4'h8, 0, 0, 0, 4'h0);
    chk("rel.id", 0, {30'd0, active_id}, 32'd3);
    chk("rel.addr", 0, isr_addr, 32'h400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
